// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and edge-detect push buttons (optional auto-repeat under BTN_REPEAT_EN)
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               btn_any
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] s1, s2;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] stable_nxt;
    logic [NUM_BTN-1:0] accept;
    logic [NUM_BTN-1:0] rise, fall;
    logic [NUM_BTN-1:0] rep_fire;
    logic [CW-1:0]      cnt [NUM_BTN];

    // Two-flop synchroniser bringing the asynchronous button levels into clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // A bit is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
        stable_nxt = stable ^ accept;
        rise       = accept & ~stable;
        fall       = accept & stable;
    end

    // Debounce counters: any agreeing sample restarts the count; acceptance clears it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (reset || (s2[i] == stable[i]) || (cnt[i] == CNT_MAX)) begin
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + CW'(1);
            end
        end
        if (reset) begin
            stable <= '0;
        end else begin
            stable <= stable_nxt;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_M1 = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_M1 = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]      rcnt [NUM_BTN];
    logic [NUM_BTN-1:0] rphase;

    // Repeat fires while held; first gap is the delay, later gaps the period. A release wins.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_fire[i] = stable[i] && !fall[i] && (rcnt[i] == (rphase[i] ? RP_M1 : RD_M1));
        end
    end

    // Repeat counters idle at zero while released and restart after every repeat pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (reset || !stable[i] || fall[i]) begin
                rcnt[i]   <= '0;
                rphase[i] <= 1'b0;
            end else if (rep_fire[i]) begin
                rcnt[i]   <= '0;
                rphase[i] <= 1'b1;
            end else begin
                rcnt[i]   <= rcnt[i] + RW'(1);
            end
        end
    end
`else
    // Without auto-repeat only genuine 0->1 edges produce press pulses.
    always_comb begin
        rep_fire = '0;
    end
`endif

    // Registered one-cycle pulses and the any-button flag, aligned with the level change.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_press   <= '0;
            btn_release <= '0;
            btn_any     <= 1'b0;
        end else begin
            btn_press   <= rise | rep_fire;
            btn_release <= fall;
            btn_any     <= |stable_nxt;
        end
    end

    assign btn_level = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner against a window-based model
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          btn_any;

    button_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .btn_any(btn_any)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: synchronised samples seen so far, and derived state
    logic [NB-1:0] d1, d2;
    logic [NB-1:0] hist [$];
    logic [NB-1:0] m_level, m_press, m_rel;
    int            since [NB];

    // scenario bookkeeping
    int pc [NB];
    int rc [NB];
    int first_press [NB];
    int first_rel [NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] raw, input logic rst);
        logic [NB-1:0] s2b;
        logic          flip;
        if (rst) begin
            d1 = '0; d2 = '0; hist.delete();
            m_level = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < NB; i++) since[i] = 0;
        end else begin
            s2b = d2;
            hist.push_back(s2b);
            if (hist.size() > DC) void'(hist.pop_front());
            d2 = d1;
            d1 = raw;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NB; i++) begin
                flip = (hist.size() == DC);
                for (int j = 0; j < hist.size(); j++)
                    if (hist[j][i] == m_level[i]) flip = 1'b0;
                if (flip && !m_level[i]) begin
                    m_level[i] = 1'b1; m_press[i] = 1'b1; since[i] = 0;
                end else if (flip) begin
                    m_level[i] = 1'b0; m_rel[i] = 1'b1;
                end else if (m_level[i]) begin
                    since[i]++;
`ifdef BTN_REPEAT_EN
                    if (since[i] == RD || (since[i] > RD && (since[i] - RD) % RP == 0))
                        m_press[i] = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic step(input logic [NB-1:0] raw, input logic rst);
        btn_raw = raw;
        reset   = rst;
        @(posedge clk);
        cyc++;
        model_edge(raw, rst);
        #1;
        check("level",   32'(btn_level),   32'(m_level));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
        check("any",     32'(btn_any),     32'(|m_level));
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i]) begin
                pc[i]++;
                if (first_press[i] < 0) first_press[i] = cyc;
            end
            if (btn_release[i]) begin
                rc[i]++;
                if (first_rel[i] < 0) first_rel[i] = cyc;
            end
        end
    endtask

    task automatic steps(input logic [NB-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NB; i++) begin
            pc[i] = 0; rc[i] = 0; first_press[i] = -1; first_rel[i] = -1;
        end
    endtask

    initial begin
        int n0, e0;
        logic [NB-1:0] r;
        int len;
        logic rr;

        model_edge('0, 1'b1);
        clear_stats();

        // reset state
        for (int k = 0; k < 3; k++) step(3'b000, 1'b1);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_any",   32'(btn_any),   32'h0);

        // clean press on bit 0
        clear_stats();
        n0 = cyc + 1;
        steps(3'b001, 10);
        check("clean_press_edge", 32'(first_press[0]), 32'(n0 + 5));
        check("clean_press_cnt",  32'(pc[0]), 32'd1);
        check("clean_others",     32'(pc[1] + pc[2]), 32'd0);
        steps(3'b000, 8);
        check("clean_rel_cnt",    32'(rc[0]), 32'd1);

        // bounce on bit 1: 3-cycle high, low, 1-cycle high, then low
        clear_stats();
        steps(3'b010, 3);
        steps(3'b000, 1);
        steps(3'b010, 1);
        steps(3'b000, 8);
        check("bounce_press", 32'(pc[1]), 32'd0);
        check("bounce_rel",   32'(rc[1]), 32'd0);
        steps(3'b010, 20);
        check("held_press",   32'(pc[1]), 32'd1);
        n0 = cyc + 1;
        steps(3'b000, 10);
        check("held_rel_cnt",  32'(rc[1]), 32'd1);
        check("held_rel_edge", 32'(first_rel[1]), 32'(n0 + 5));

        // simultaneous press/release on bits 0 and 2
        clear_stats();
        steps(3'b101, 8);
        check("simul_press_same", 32'(first_press[0]), 32'(first_press[2]));
        check("simul_press_cnt",  32'(pc[0] + pc[2]), 32'd2);
        steps(3'b000, 8);
        check("simul_rel_same",   32'(first_rel[0]), 32'(first_rel[2]));
        check("simul_rel_cnt",    32'(rc[0] + rc[2]), 32'd2);

        // reset while bit 2 is held
        steps(3'b100, 8);
        check("pre_rst_level", 32'(btn_level), 32'h4);
        step(3'b100, 1'b1);
        check("mid_rst_level", 32'(btn_level), 32'h0);
        check("mid_rst_press", 32'(btn_press), 32'h0);
        check("mid_rst_any",   32'(btn_any),   32'h0);
        clear_stats();
        n0 = cyc + 1;
        steps(3'b100, 10);
        check("post_rst_press_edge", 32'(first_press[2]), 32'(n0 + 5));
        steps(3'b000, 8);

        // long hold on bit 2: release lands at E+30
        clear_stats();
        steps(3'b100, 30);
        e0 = first_press[2];
        steps(3'b000, 10);
        check("hold30_rel_edge", 32'(first_rel[2]), 32'(e0 + 30));
`ifdef BTN_REPEAT_EN
        check("hold30_press_cnt", 32'(pc[2]), 32'd8);
`else
        check("hold30_press_cnt", 32'(pc[2]), 32'd1);
`endif

        // release coinciding with a repeat slot (E+31)
        clear_stats();
        steps(3'b100, 31);
        e0 = first_press[2];
        steps(3'b000, 10);
        check("hold31_rel_edge", 32'(first_rel[2]), 32'(e0 + 31));
`ifdef BTN_REPEAT_EN
        check("hold31_press_cnt", 32'(pc[2]), 32'd8);
`else
        check("hold31_press_cnt", 32'(pc[2]), 32'd1);
`endif

        // random segments with occasional reset
        for (int s = 0; s < 150; s++) begin
            r   = NB'($urandom);
            len = $urandom_range(1, 8);
            rr  = ($urandom_range(0, 40) == 0);
            if (rr) step(r, 1'b1);
            steps(r, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
